// File: rtl/gsplat_tile_writer.sv
// Tile write-back engine: gathers one row of rasterized pixels into a small
// buffer, then streams it to DDR3 as a single Avalon burst per tile row.
module gsplat_tile_writer #(
  parameter int unsigned TILE_W = 16,
  parameter int unsigned TILE_H = 16,
  parameter int unsigned STRIDE = 2560
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [5:0]  tile_x,
  input  logic [4:0]  tile_y,
  input  logic [31:0] fb_base,
  input  logic        px_valid,
  input  logic [31:0] px_data,
  output logic        px_ready,
  output logic        busy,
  output logic        done,
  input  logic        ddram_busy,
  output logic        ddram_we,
  output logic [28:0] ddram_addr,
  output logic [7:0]  ddram_burstcnt,
  output logic [63:0] ddram_din,
  output logic [7:0]  ddram_be
);

  localparam int unsigned Words = TILE_W / 2;
  localparam int unsigned PixW  = (TILE_W > 1) ? $clog2(TILE_W) : 1;
  localparam int unsigned BeatW = (Words > 1) ? $clog2(Words) : 1;
  localparam int unsigned RowW  = (TILE_H > 1) ? $clog2(TILE_H) : 1;

  typedef enum logic [1:0] {StIdle, StFill, StBurst, StDone} state_e;

  state_e            state_q, state_d;
  logic [PixW-1:0]   pix_q, pix_d;
  logic [BeatW-1:0]  beat_q, beat_d;
  logic [RowW-1:0]   row_q, row_d;
  logic [5:0]        tile_x_q;
  logic [4:0]        tile_y_q;
  logic [31:0]       base_q;
  logic [63:0]       row_buf_q [2**BeatW];

  logic              px_fire, beat_fire;
  logic [BeatW-1:0]  wr_word;
  logic [31:0]       row_idx, burst_addr;
  logic [63:0]       din_d;

  assign px_fire   = (state_q == StFill) && px_valid;
  assign beat_fire = (state_q == StBurst) && !ddram_busy;
  assign wr_word   = BeatW'(pix_q >> 1);

  // Byte address of the current tile row; wraps at 32 bits.
  assign row_idx    = 32'(tile_y_q) * 32'(TILE_H) + 32'(row_q);
  assign burst_addr = base_q + row_idx * 32'(STRIDE) + 32'(tile_x_q) * 32'(TILE_W * 4);

  // Next-state and counter update.
  always_comb begin
    state_d = state_q;
    pix_d   = pix_q;
    beat_d  = beat_q;
    row_d   = row_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StFill;
          pix_d   = '0;
          beat_d  = '0;
          row_d   = '0;
        end
      end
      StFill: begin
        if (px_fire) begin
          if (pix_q == PixW'(TILE_W - 1)) begin
            pix_d   = '0;
            beat_d  = '0;
            state_d = StBurst;
          end else begin
            pix_d = pix_q + 1'b1;
          end
        end
      end
      StBurst: begin
        if (beat_fire) begin
          if (beat_q == BeatW'(Words - 1)) begin
            beat_d = '0;
            if (row_q == RowW'(TILE_H - 1)) begin
              state_d = StDone;
            end else begin
              row_d   = row_q + 1'b1;
              state_d = StFill;
            end
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Write data for the next cycle; bypasses the buffer when the word is written this cycle.
  always_comb begin
    din_d = row_buf_q[beat_d];
    if (px_fire && (wr_word == beat_d)) begin
      din_d = pix_q[0] ? {px_data, row_buf_q[wr_word][31:0]}
                       : {row_buf_q[wr_word][63:32], px_data};
    end
  end

  // State, counters, latched request and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= StIdle;
      pix_q          <= '0;
      beat_q         <= '0;
      row_q          <= '0;
      tile_x_q       <= '0;
      tile_y_q       <= '0;
      base_q         <= '0;
      px_ready       <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      ddram_we       <= 1'b0;
      ddram_be       <= '0;
      ddram_burstcnt <= '0;
      ddram_addr     <= '0;
      ddram_din      <= '0;
    end else begin
      state_q        <= state_d;
      pix_q          <= pix_d;
      beat_q         <= beat_d;
      row_q          <= row_d;
      if (state_q == StIdle && start) begin
        tile_x_q <= tile_x;
        tile_y_q <= tile_y;
        base_q   <= fb_base;
      end
      px_ready       <= (state_d == StFill);
      busy           <= (state_d == StFill) || (state_d == StBurst);
      done           <= (state_d == StDone);
      ddram_we       <= (state_d == StBurst);
      ddram_be       <= (state_d == StBurst) ? 8'hFF : 8'h00;
      ddram_burstcnt <= (state_d == StBurst) ? 8'(Words) : 8'h00;
      // Address tracks the row while filling and is frozen for the whole burst.
      if (state_q == StFill) ddram_addr <= burst_addr[31:3];
      ddram_din      <= din_d;
    end
  end

  // Row buffer: even pixels to the low half, odd pixels to the high half.
  always_ff @(posedge clk) begin
    if (px_fire) begin
      if (pix_q[0]) row_buf_q[wr_word][63:32] <= px_data;
      else          row_buf_q[wr_word][31:0]  <= px_data;
    end
  end

endmodule

// File: tb/tb_gsplat_tile_writer.sv
// Self-checking bench for gsplat_tile_writer: scoreboard of expected DDR beats.
module tb_gsplat_tile_writer;

  localparam int TW = 16;
  localparam int TH = 16;
  localparam int ST = 2560;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  tile_x = '0;
  logic [4:0]  tile_y = '0;
  logic [31:0] fb_base = '0;
  logic        px_valid = 1'b1;
  logic [31:0] px_data = '0;
  logic        ddram_busy = 1'b0;
  logic        px_ready, busy, done, ddram_we;
  logic [28:0] ddram_addr;
  logic [7:0]  ddram_burstcnt, ddram_be;
  logic [63:0] ddram_din;

  gsplat_tile_writer dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .tile_x         (tile_x),
    .tile_y         (tile_y),
    .fb_base        (fb_base),
    .px_valid       (px_valid),
    .px_data        (px_data),
    .px_ready       (px_ready),
    .busy           (busy),
    .done           (done),
    .ddram_busy     (ddram_busy),
    .ddram_we       (ddram_we),
    .ddram_addr     (ddram_addr),
    .ddram_burstcnt (ddram_burstcnt),
    .ddram_din      (ddram_din),
    .ddram_be       (ddram_be)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [28:0] exp_addr_q[$];
  logic [63:0] exp_din_q[$];

  // Monitor / driver shared state
  int          fire_cnt, burst_cnt, done_cnt, done_cyc, start_cyc, pidx;
  logic [28:0] first_addr, second_addr, last_addr, prev_addr;
  logic [63:0] first_din, prev_din;
  logic        prev_we = 1'b0, prev_busy = 1'b0, acc = 1'b0;
  logic [31:0] seed = '0;
  logic        toggle = 1'b0, stall_en = 1'b0, stall_done = 1'b0;
  int          stall_left = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pix(input logic [31:0] sd, input int idx);
    return sd ^ (32'(idx + 1) * 32'h1111_1111);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: sampled on the falling edge.
  always @(negedge clk) begin
    if (ddram_we && !prev_we) begin
      burst_cnt++;
      if (burst_cnt == 1) first_addr = ddram_addr;
      if (burst_cnt == 2) second_addr = ddram_addr;
      last_addr = ddram_addr;
    end
    if (ddram_we && prev_we && prev_busy) begin
      check_eq("hold_addr", 64'(ddram_addr), 64'(prev_addr));
      check_eq("hold_din", ddram_din, prev_din);
    end
    if (ddram_we && !ddram_busy) begin
      if (exp_addr_q.size() == 0) begin
        check_eq("sb_underflow", 64'(exp_addr_q.size()), 64'd1);
      end else begin
        check_eq("beat_addr", 64'(ddram_addr), 64'(exp_addr_q.pop_front()));
        check_eq("beat_din", ddram_din, exp_din_q.pop_front());
      end
      check_eq("beat_be", 64'(ddram_be), 64'hFF);
      check_eq("beat_burstcnt", 64'(ddram_burstcnt), 64'(TW / 2));
      if (fire_cnt == 0) first_din = ddram_din;
      fire_cnt++;
    end
    if (!ddram_we) check_eq("be_idle", 64'(ddram_be), 64'h0);
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    acc       = px_valid && px_ready;
    prev_we   = ddram_we;
    prev_busy = ddram_busy;
    prev_addr = ddram_addr;
    prev_din  = ddram_din;
  end

  // Pixel source and DDR waitrequest driver, updated just after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (acc) pidx++;
      px_valid = toggle ? ~px_valid : 1'b1;
      px_data  = pix(seed, pidx);
      if (stall_en && !stall_done && ddram_we && fire_cnt == 3) begin
        stall_left = 5;
        stall_done = 1'b1;
      end
      ddram_busy = (stall_left > 0);
      if (stall_left > 0) stall_left--;
    end
  end

  // Runs one tile; called just after a rising edge with the DUT idle.
  task automatic run_tile(input logic [5:0] x, input logic [4:0] y, input logic [31:0] base,
                          input logic [31:0] sd, input logic tog, input logic stl,
                          input logic dbl, input int exp_dly, input logic [28:0] exp_first,
                          input logic [28:0] exp_last, input int rst_at);
    logic rst_hit;
    logic [31:0] a;
    rst_hit = 1'b0;
    seed = sd; pidx = 0; toggle = tog; stall_en = stl; stall_done = 1'b0;
    fire_cnt = 0; burst_cnt = 0; done_cnt = 0; done_cyc = 0;
    exp_addr_q.delete(); exp_din_q.delete();
    for (int r = 0; r < TH; r++) begin
      a = base + 32'((int'(y) * TH + r) * ST) + 32'(int'(x) * TW * 4);
      for (int b = 0; b < TW / 2; b++) begin
        exp_addr_q.push_back(a[31:3]);
        exp_din_q.push_back({pix(sd, r * TW + 2 * b + 1), pix(sd, r * TW + 2 * b)});
      end
    end
    tile_x = x; tile_y = y; fb_base = base;
    start = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 3000 && done_cnt == 0 && !rst_hit; i++) begin
      if (dbl && i == 4) begin
        start = 1'b1; tile_x = x + 6'd1;
      end else if (dbl && i == 5) begin
        start = 1'b0; tile_x = x;
      end
      if (rst_at > 0 && fire_cnt == rst_at && ddram_we) begin
        reset_n = 1'b0;
        #1;
        check_eq("rst_we", 64'(ddram_we), 64'h0);
        check_eq("rst_busy", 64'(busy), 64'h0);
        check_eq("rst_addr", 64'(ddram_addr), 64'h0);
        rst_hit = 1'b1;
      end else begin
        @(posedge clk); #1;
      end
    end
    if (rst_hit) begin
      @(posedge clk); #1;
      check_eq("rst_held_we", 64'(ddram_we), 64'h0);
      toggle = 1'b0;
      exp_addr_q.delete(); exp_din_q.delete();
      reset_n = 1'b1;
      return;
    end
    repeat (3) begin
      @(posedge clk); #1;
    end
    toggle = 1'b0; stall_en = 1'b0;
    check_eq("done_pulses", 64'(done_cnt), 64'd1);
    if (exp_dly > 0) check_eq("done_cycle", 64'(done_cyc - start_cyc), 64'(exp_dly));
    check_eq("burst_count", 64'(burst_cnt), 64'(TH));
    check_eq("beat_count", 64'(fire_cnt), 64'(TH * TW / 2));
    check_eq("sb_leftover", 64'(exp_addr_q.size()), 64'd0);
    check_eq("first_addr", 64'(first_addr), 64'(exp_first));
    check_eq("last_addr", 64'(last_addr), 64'(exp_last));
    check_eq("idle_busy", 64'(busy), 64'h0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_px_ready", 64'(px_ready), 64'h0);
    check_eq("reset_busy", 64'(busy), 64'h0);
    check_eq("reset_done", 64'(done), 64'h0);
    check_eq("reset_we", 64'(ddram_we), 64'h0);
    check_eq("reset_be", 64'(ddram_be), 64'h0);
    check_eq("reset_burstcnt", 64'(ddram_burstcnt), 64'h0);
    check_eq("reset_addr", 64'(ddram_addr), 64'h0);
    check_eq("reset_din", ddram_din, 64'h0);
    reset_n = 1'b1;

    // Tile (0,0), start in the first cycle after reset release.
    run_tile(6'd0, 5'd0, 32'h3000_0000, 32'h0, 1'b0, 1'b0, 1'b0, 385,
             29'h0600_0000, 29'h0600_12C0, 0);
    check_eq("row1_addr", 64'(second_addr), 64'h0600_0140);
    check_eq("beat0_din", first_din, 64'h2222_2222_1111_1111);

    // Bottom-right tile.
    run_tile(6'd39, 5'd29, 32'h3000_0000, 32'hA5A5_0000, 1'b0, 1'b0, 1'b0, 385,
             29'h0602_4538, 29'h0602_57F8, 0);

    // Five-cycle waitrequest on beat 3.
    run_tile(6'd3, 5'd2, 32'h3000_0000, 32'h5A5A_1234, 1'b0, 1'b1, 1'b0, 390,
             29'h0600_2818, 29'h0600_3AD8, 0);

    // Stray start while filling, with px_valid toggling.
    run_tile(6'd5, 5'd1, 32'h3000_0000, 32'hC3C3_8765, 1'b1, 1'b0, 1'b1, 0,
             29'h0600_1428, 29'h0600_26E8, 0);

    // Reset during beat 4 of row 2, then a new tile straight after release.
    run_tile(6'd0, 5'd0, 32'h3000_0000, 32'h0F0F_0F0F, 1'b0, 1'b0, 1'b0, 0,
             29'h0, 29'h0, 20);
    run_tile(6'd1, 5'd0, 32'h3000_0000, 32'h7777_0001, 1'b0, 1'b0, 1'b0, 385,
             29'h0600_0008, 29'h0600_12C8, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gsplat_tile_writer.md
GSPLAT_TILE_WRITER -- requirements
Module: gsplat_tile_writer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; ports are named clk and reset_n.
REQ-002 Parameter TILE_W, default 16, tile width in pixels; SHALL be even.
REQ-003 Parameter TILE_H, default 16, tile height in pixels.
REQ-004 Parameter STRIDE, default 2560, framebuffer row pitch in bytes (640 px x 4 bytes).
REQ-005 clk  in  1  system clock.
REQ-006 reset_n  in  1  asynchronous active-low reset.
REQ-007 start  in  1  single-cycle request to write back one tile.
REQ-008 tile_x  in  6  tile column, 0..39.
REQ-009 tile_y  in  5  tile row, 0..29.
REQ-010 fb_base  in  32  framebuffer byte address; SHALL be 8-byte aligned.
REQ-011 px_valid  in  1  pixel-stream valid from the rasterizer tile buffer.
REQ-012 px_data  in  32  pixel, 32bpp, raster order within the tile.
REQ-013 px_ready  out  1  pixel accepted when px_valid & px_ready.
REQ-014 busy  out  1  high from the cycle after start is accepted until done.
REQ-015 done  out  1  one-cycle pulse when the final burst completes.
REQ-016 ddram_busy  in  1  DDR3 Avalon waitrequest.
REQ-017 ddram_we  out  1  write request.
REQ-018 ddram_addr  out  29  64-bit word address.
REQ-019 ddram_burstcnt  out  8  burst length.
REQ-020 ddram_din  out  64  write data.
REQ-021 ddram_be  out  8  byte enables.

Function
REQ-022 The FSM SHALL have four states: IDLE, FILL, BURST and DONE. Transitions: IDLE->FILL on start; FILL->BURST after TILE_W pixels are accepted; BURST->FILL after the last beat if rows remain; BURST->DONE after the last beat of row TILE_H-1; DONE->IDLE unconditionally. No transition adds idle cycles.
REQ-023 In IDLE, a start pulse SHALL latch tile_x, tile_y and fb_base, and clear the row and pixel counters. A start pulse in any other state SHALL be ignored.
REQ-024 px_ready SHALL be 1 only in FILL.
REQ-025 Accepted pixel n of a row SHALL be stored in row-buffer word n/2. Even n goes to bits [31:0] and odd n to bits [63:32], so the lower x is at the lower address.
REQ-026 In BURST, the block SHALL drive ddram_we=1, ddram_burstcnt=TILE_W/2, ddram_be=8'hFF and ddram_din=buffer[beat].
REQ-027 In BURST, beat SHALL advance only when ddram_we & ~ddram_busy. Address and data SHALL be held stable while ddram_busy=1.
REQ-028 ddram_addr SHALL hold for the whole burst and equal bits [31:3] of fb_base + (tile_y*TILE_H + row)*STRIDE + tile_x*TILE_W*4, computed in 32 bits with wrap on overflow.
REQ-029 Outside BURST, ddram_we and ddram_be SHALL be 0. ddram_din, ddram_addr and ddram_burstcnt are then don't-care but registered.
REQ-030 done SHALL be 1 exactly in the DONE cycle. busy SHALL be 1 in FILL and BURST.
REQ-031 A px_valid stall in FILL SHALL hold the counters. A ddram_busy stall in BURST SHALL hold the beat counter. There is no other stall source.
REQ-032 With px_valid=1 and ddram_busy=0 throughout, and start sampled in cycle 0, each row SHALL take TILE_W + TILE_W/2 cycles, and done SHALL be high in cycle 385 for the default parameters.
REQ-033 All outputs SHALL be registered.

Reset
REQ-034 Asserting reset_n=0 SHALL force, asynchronously: state IDLE; px_ready, busy, done, ddram_we, ddram_be, ddram_burstcnt = 0; ddram_addr and ddram_din = 0; all counters = 0.
REQ-035 Reset mid-burst SHALL drop ddram_we immediately without completing the burst. After release, the block SHALL wait in IDLE for a new start.
REQ-036 Start asserted in the first cycle after reset release SHALL be accepted.

Verification
REQ-037 Tile (0,0), fb_base=0x30000000, px_valid=1, ddram_busy=0 -> row 0 burst addr 0x06000000, row 1 addr 0x06000140, 16 bursts of burstcnt 8, done in cycle 385.
REQ-038 Tile (39,29), same base -> first burst addr 0x06024538, last burst addr 0x060257F8.
REQ-039 Row-0 pixels 0x11111111 then 0x22222222 -> beat 0 ddram_din=0x2222222211111111 with be=0xFF.
REQ-040 ddram_busy held high for 5 cycles on beat 3 -> addr and din for beat 3 stable throughout, 8 beats total, done delayed by exactly 5 cycles.
REQ-041 Second start pulse in FILL, and px_valid toggling every cycle -> second start ignored, no pixel lost or duplicated, single done pulse.
REQ-042 reset_n low during beat 4 of row 2 -> ddram_we=0 in the same cycle, busy=0. A following start on tile (1,0) -> first addr 0x06000008.
